// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer driving an external full_adder cell
//
// Purpose:
//   Accepts a pair of WIDTH-bit operands plus carry-in over a valid/ready
//   handshake, then feeds them LSB first through one external 1-bit full
//   adder, one bit per clock. The running carry lives in a flop between bits.
//   When all WIDTH bits are done the result is presented on sum_o/cout_o
//   until the downstream accepts it.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   in_valid_i   operand beat valid
//   in_ready_o   controller can accept an operand beat (IDLE only)
//   a_i, b_i     WIDTH-bit operands
//   cin_i        carry into bit 0
//   out_valid_o  result valid (DONE only)
//   out_ready_i  downstream accepts result
//   sum_o        low WIDTH bits of a+b+cin, held until the next result
//   cout_o       carry out of bit WIDTH-1
//   fa_a_o       full_adder A input (0 outside RUN)
//   fa_b_o       full_adder B input (0 outside RUN)
//   fa_c_o       full_adder carry input (0 outside RUN)
//   fa_f_i       full_adder output: [0]=sum bit, [1]=carry out

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             fa_a_o,
  output logic             fa_b_o,
  output logic             fa_c_o,
  input  logic [1:0]       fa_f_i
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             run;

  // New sum bits enter at the MSB so that after WIDTH shifts bit 0 of the
  // operands ends up at bit 0 of the result.
  assign sum_sh_d = {fa_f_i[0], sum_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            a_sh_q     <= a_i;
            b_sh_q     <= b_i;
            carry_q    <= cin_i;
            cnt_q      <= '0;
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_f_i[1];
          if (cnt_q == CNT_LAST) begin
            // Final bit: publish the completed result directly so sum_o only
            // changes at the RUN->DONE boundary and stays put otherwise.
            sum_q       <= sum_sh_d;
            cout_q      <= fa_f_i[1];
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign run         = (state_q == S_RUN);
  assign fa_a_o      = run & a_sh_q[0];
  assign fa_b_o      = run & b_sh_q[0];
  assign fa_c_o      = run & carry_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl with an attached full adder

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         fa_a_o;
  logic         fa_b_o;
  logic         fa_c_o;
  logic [1:0]   fa_f_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  // The external 1-bit full adder cell.
  assign fa_f_i[0] = fa_a_o ^ fa_b_o ^ fa_c_o;
  assign fa_f_i[1] = (fa_a_o & fa_b_o) | (fa_c_o & (fa_a_o ^ fa_b_o));

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .fa_a_o      (fa_a_o),
    .fa_b_o      (fa_b_o),
    .fa_c_o      (fa_c_o),
    .fa_f_i      (fa_f_i)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one complete operation; returns {cout,sum} and the number of edges
  // from the accept edge until out_valid_o was first seen high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int hold, output logic [W:0] res, output int lat);
    int t;
    t = 0;
    while (!in_ready_o && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready_o) check("wait_in_ready", 32'(in_ready_o), 32'd1);
    a_i = a;
    b_i = b;
    cin_i = c;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    a_i = W'($urandom);
    b_i = W'($urandom);
    cin_i = 1'($urandom);
    lat = 0;
    while (!out_valid_o && lat < 50) begin
      tick();
      lat++;
    end
    res = {cout_o, sum_o};
    repeat (hold) tick();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  initial begin
    logic [W:0]   res;
    logic [W:0]   model;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W-1:0] held_sum;
    logic         held_cout;
    int           lat;
    int           cyc;
    int           acc_cyc[$];
    logic [W:0]   results[$];
    logic         pre_rdy;
    logic         pre_vld;
    int           n_acc;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[6] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};
    vecs[7] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sum: 8'h00, cout: 1'b1};

    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    a_i = '0;
    b_i = '0;
    cin_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;

    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_sum", 32'(sum_o), 32'd0);
    check("rst_cout", 32'(cout_o), 32'd0);
    check("rst_fa", {29'd0, fa_a_o, fa_b_o, fa_c_o}, 32'd0);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, res, lat);
      check($sformatf("vec%0d_result", i), 32'(res), 32'({vecs[i].cout, vecs[i].sum}));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
    end

    // Backpressure: hold in DONE while offering new operands.
    a_i = 8'h5A; b_i = 8'h3C; cin_i = 1'b0; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    cyc = 0;
    while (!out_valid_o && cyc < 50) begin tick(); cyc++; end
    check("bp_valid", 32'(out_valid_o), 32'd1);
    held_sum = sum_o;
    held_cout = cout_o;
    check("bp_sum_initial", {23'd0, held_cout, held_sum}, 32'h096);
    for (int i = 0; i < 5; i++) begin
      in_valid_i = ~in_valid_i;
      a_i = W'($urandom);
      b_i = W'($urandom);
      cin_i = 1'($urandom);
      tick();
      check($sformatf("bp%0d_sum", i), 32'(sum_o), 32'(held_sum));
      check($sformatf("bp%0d_cout", i), 32'(cout_o), 32'(held_cout));
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready_o), 32'd0);
      check($sformatf("bp%0d_out_valid", i), 32'(out_valid_o), 32'd1);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("bp_release_valid", 32'(out_valid_o), 32'd0);
    check("bp_release_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("bp_nothing_taken", 32'(in_ready_o), 32'd1);

    // Mid-RUN reset, also watching the full-adder drive for the first bits.
    a_i = 8'h01; b_i = 8'h00; cin_i = 1'b1; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("run_fa_bit0", {29'd0, fa_a_o, fa_b_o, fa_c_o}, 32'b101);
    check("run_in_ready", 32'(in_ready_o), 32'd0);
    tick();
    check("run_fa_bit1", {29'd0, fa_a_o, fa_b_o, fa_c_o}, 32'b001);
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mrst_in_ready", 32'(in_ready_o), 32'd1);
    check("mrst_out_valid", 32'(out_valid_o), 32'd0);
    check("mrst_sum", {23'd0, cout_o, sum_o}, 32'd0);
    check("mrst_fa", {29'd0, fa_a_o, fa_b_o, fa_c_o}, 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 0, res, lat);
    check("mrst_fresh", 32'(res), 32'h002);

    // Back-to-back with in_valid_i and out_ready_i held high.
    out_ready_i = 1'b1;
    a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0; in_valid_i = 1'b1;
    n_acc = 0;
    cyc = 0;
    while (results.size() < 2 && cyc < 60) begin
      pre_rdy = in_ready_o;
      pre_vld = out_valid_o;
      if (pre_vld) results.push_back({cout_o, sum_o});
      tick();
      cyc++;
      if (pre_rdy && in_valid_i) begin
        acc_cyc.push_back(cyc);
        n_acc++;
        if (n_acc == 1) begin
          a_i = 8'h80; b_i = 8'h80; cin_i = 1'b0;
        end else begin
          in_valid_i = 1'b0;
        end
      end
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    check("b2b_n_results", 32'(results.size()), 32'd2);
    check("b2b_n_accepts", 32'(acc_cyc.size()), 32'd2);
    if (results.size() == 2) begin
      check("b2b_res0", 32'(results[0]), 32'h030);
      check("b2b_res1", 32'(results[1]), 32'h100);
    end
    if (acc_cyc.size() == 2) check("b2b_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
    tick();

    // Random operations against plain arithmetic.
    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, int'($urandom_range(0, 2)), res, lat);
      check($sformatf("rand%0d_%0h_%0h_%0h", i, ra, rb, rc), 32'(res), 32'(model));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(W));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
